// File: rtl/pipe_ctrl_if.sv
// Control-unit boundary: IF/ID decode inputs, ALU flags, and per-stage control outputs.
interface pipe_ctrl_if #(
  parameter int ALUOP_W = 3,
  parameter int REG_AW  = 5
);
  logic [31:0]        id_instr;
  logic               id_valid;
  logic               id_rt_zero;
  logic [3:0]         ex_nzcv;
  logic               id_reg2loc;
  logic               id_br_taken;
  logic               id_uncond_br;
  logic               pc_write_en;
  logic               flush_if;
  logic               illegal;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [1:0]         ex_alu_src;
  logic               ex_flag_write;
  logic               mem_mem_write;
  logic               mem_mem_to_reg;
  logic               wb_reg_write;
  logic [REG_AW-1:0]  wb_rd;
  logic [3:0]         flags_q;

  modport master (
    output id_instr, id_valid, id_rt_zero, ex_nzcv,
    input  id_reg2loc, id_br_taken, id_uncond_br, pc_write_en, flush_if, illegal,
    input  ex_alu_op, ex_alu_src, ex_flag_write, mem_mem_write, mem_mem_to_reg,
    input  wb_reg_write, wb_rd, flags_q
  );

  modport slave (
    input  id_instr, id_valid, id_rt_zero, ex_nzcv,
    output id_reg2loc, id_br_taken, id_uncond_br, pc_write_en, flush_if, illegal,
    output ex_alu_op, ex_alu_src, ex_flag_write, mem_mem_write, mem_mem_to_reg,
    output wb_reg_write, wb_rd, flags_q
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// LEGv8 5-stage control: ID decode, ID/EX-EX/MEM-MEM/WB control bundles, NZCV register,
// load-use and flag stalls, ID-stage resolution of B, CBZ and B.LT.
module pipe_ctrl_unit #(
  parameter int ALUOP_W     = 3,
  parameter int REG_AW      = 5,
  parameter int EN_FLAG_FWD = 1,
  parameter int DELAY_SLOT  = 1
) (
  input logic       clk,
  input logic       reset_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [ALUOP_W-1:0] ALU_PASS = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_EOR  = ALUOP_W'(3'b110);
  localparam logic [1:0] SRC_REG   = 2'b00;
  localparam logic [1:0] SRC_DADDR = 2'b01;
  localparam logic [1:0] SRC_IMM12 = 2'b10;
  localparam logic [1:0] SRC_SHAMT = 2'b11;
  localparam logic [REG_AW-1:0] XZR = '1;

  typedef enum logic [3:0] {
    OP_NONE, OP_ADDS, OP_ADDI, OP_AND, OP_EOR, OP_SUBS, OP_LDUR,
    OP_STUR, OP_LSR, OP_B, OP_CBZ, OP_BLT
  } op_e;

  op_e                op;
  logic               id_live;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic [1:0]         dec_alu_src;
  logic               dec_flag_write, dec_mem_write, dec_mem_to_reg, dec_reg_write;
  logic               dec_reg2loc, use_rn, use_r2, is_b, is_cbz, is_blt;
  logic [REG_AW-1:0]  id_rn, id_r2;
  logic               load_use, ex_setter, flag_stall, stall, lt_cond, br_raw;
  logic [3:0]         nzcv_src;

  logic               ex_valid_q, ex_valid_d;
  logic [ALUOP_W-1:0] ex_alu_op_q, ex_alu_op_d;
  logic [1:0]         ex_alu_src_q, ex_alu_src_d;
  logic               ex_flag_write_q, ex_flag_write_d;
  logic               ex_mem_write_q, ex_mem_write_d;
  logic               ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic               ex_reg_write_q, ex_reg_write_d;
  logic [REG_AW-1:0]  ex_rd_q, ex_rd_d;
  logic               mem_valid_q, mem_mem_write_q, mem_mem_to_reg_q, mem_reg_write_q;
  logic [REG_AW-1:0]  mem_rd_q;
  logic               wb_valid_q, wb_reg_write_q;
  logic [REG_AW-1:0]  wb_rd_q;
  logic [3:0]         flags_q, flags_d;
  logic               unused_bits;

  // Decode is forced to a bubble while reset is asserted.
  assign id_live = bus.id_valid & reset_n;

  always_comb begin
    op = OP_NONE;
    casez (bus.id_instr[31:21])
      11'b10101011000: op = OP_ADDS;
      11'b1001000100?: op = OP_ADDI;
      11'b10001010000: op = OP_AND;
      11'b11001010000: op = OP_EOR;
      11'b11101011000: op = OP_SUBS;
      11'b11111000010: op = OP_LDUR;
      11'b11111000000: op = OP_STUR;
      11'b11010011010: op = OP_LSR;
      11'b000101?????: op = OP_B;
      11'b10110100???: op = OP_CBZ;
      11'b01010100???: op = OP_BLT;
      default:         op = OP_NONE;
    endcase
  end

  always_comb begin
    dec_alu_op     = ALU_PASS;
    dec_alu_src    = SRC_REG;
    dec_flag_write = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_write  = 1'b0;
    dec_reg2loc    = 1'b0;
    use_rn         = 1'b0;
    use_r2         = 1'b0;
    is_b           = 1'b0;
    is_cbz         = 1'b0;
    is_blt         = 1'b0;
    if (id_live) begin
      case (op)
        OP_ADDS: begin dec_alu_op = ALU_ADD; dec_flag_write = 1'b1; dec_reg_write = 1'b1;
                       dec_reg2loc = 1'b1; use_rn = 1'b1; use_r2 = 1'b1; end
        OP_SUBS: begin dec_alu_op = ALU_SUB; dec_flag_write = 1'b1; dec_reg_write = 1'b1;
                       dec_reg2loc = 1'b1; use_rn = 1'b1; use_r2 = 1'b1; end
        OP_AND:  begin dec_alu_op = ALU_AND; dec_reg_write = 1'b1;
                       dec_reg2loc = 1'b1; use_rn = 1'b1; use_r2 = 1'b1; end
        OP_EOR:  begin dec_alu_op = ALU_EOR; dec_reg_write = 1'b1;
                       dec_reg2loc = 1'b1; use_rn = 1'b1; use_r2 = 1'b1; end
        OP_ADDI: begin dec_alu_op = ALU_ADD; dec_alu_src = SRC_IMM12; dec_reg_write = 1'b1;
                       dec_reg2loc = 1'b1; use_rn = 1'b1; end
        // LSR reads only Rn; the shift amount travels on the B operand.
        OP_LSR:  begin dec_alu_op = ALU_PASS; dec_alu_src = SRC_SHAMT; dec_reg_write = 1'b1;
                       dec_reg2loc = 1'b1; use_rn = 1'b1; end
        OP_LDUR: begin dec_alu_op = ALU_ADD; dec_alu_src = SRC_DADDR; dec_mem_to_reg = 1'b1;
                       dec_reg_write = 1'b1; use_rn = 1'b1; end
        OP_STUR: begin dec_alu_op = ALU_ADD; dec_alu_src = SRC_DADDR; dec_mem_write = 1'b1;
                       use_rn = 1'b1; use_r2 = 1'b1; end
        OP_CBZ:  begin use_r2 = 1'b1; is_cbz = 1'b1; end
        OP_B:    is_b = 1'b1;
        OP_BLT:  is_blt = 1'b1;
        default: ;
      endcase
    end
  end

  assign id_rn = REG_AW'(bus.id_instr[9:5]);
  assign id_r2 = dec_reg2loc ? REG_AW'(bus.id_instr[20:16]) : REG_AW'(bus.id_instr[4:0]);

  assign load_use   = ex_valid_q & ex_mem_to_reg_q & (ex_rd_q != XZR) &
                      ((use_rn & (id_rn == ex_rd_q)) | (use_r2 & (id_r2 == ex_rd_q)));
  assign ex_setter  = ex_valid_q & ex_flag_write_q;
  assign flag_stall = (EN_FLAG_FWD == 0) & is_blt & ex_setter;
  assign stall      = load_use | flag_stall;

  assign nzcv_src = ((EN_FLAG_FWD != 0) && ex_setter) ? bus.ex_nzcv : flags_q;
  assign lt_cond  = nzcv_src[3] ^ nzcv_src[0];
  assign br_raw   = is_b | (is_cbz & bus.id_rt_zero) | (is_blt & lt_cond);

  assign bus.id_reg2loc   = dec_reg2loc;
  assign bus.id_br_taken  = br_raw & ~stall;
  assign bus.id_uncond_br = is_b;
  assign bus.pc_write_en  = ~stall;
  assign bus.flush_if     = br_raw & ~stall & (DELAY_SLOT == 0);
  assign bus.illegal      = id_live & (op == OP_NONE);

  always_comb begin
    ex_valid_d      = id_live & (op != OP_NONE) & ~stall;
    ex_alu_op_d     = ALU_PASS;
    ex_alu_src_d    = SRC_REG;
    ex_flag_write_d = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_mem_to_reg_d = 1'b0;
    ex_reg_write_d  = 1'b0;
    ex_rd_d         = '0;
    if (ex_valid_d) begin
      ex_alu_op_d     = dec_alu_op;
      ex_alu_src_d    = dec_alu_src;
      ex_flag_write_d = dec_flag_write;
      ex_mem_write_d  = dec_mem_write;
      ex_mem_to_reg_d = dec_mem_to_reg;
      ex_reg_write_d  = dec_reg_write;
      ex_rd_d         = dec_reg_write ? REG_AW'(bus.id_instr[4:0]) : '0;
    end
    // EX is never frozen, so a flag-setter commits even during a stall.
    flags_d = ex_setter ? bus.ex_nzcv : flags_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q       <= 1'b0;
      ex_alu_op_q      <= '0;
      ex_alu_src_q     <= '0;
      ex_flag_write_q  <= 1'b0;
      ex_mem_write_q   <= 1'b0;
      ex_mem_to_reg_q  <= 1'b0;
      ex_reg_write_q   <= 1'b0;
      ex_rd_q          <= '0;
      mem_valid_q      <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_rd_q         <= '0;
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_rd_q          <= '0;
      flags_q          <= '0;
    end else begin
      ex_valid_q       <= ex_valid_d;
      ex_alu_op_q      <= ex_alu_op_d;
      ex_alu_src_q     <= ex_alu_src_d;
      ex_flag_write_q  <= ex_flag_write_d;
      ex_mem_write_q   <= ex_mem_write_d;
      ex_mem_to_reg_q  <= ex_mem_to_reg_d;
      ex_reg_write_q   <= ex_reg_write_d;
      ex_rd_q          <= ex_rd_d;
      mem_valid_q      <= ex_valid_q;
      mem_mem_write_q  <= ex_mem_write_q;
      mem_mem_to_reg_q <= ex_mem_to_reg_q;
      mem_reg_write_q  <= ex_reg_write_q;
      mem_rd_q         <= ex_rd_q;
      wb_valid_q       <= mem_valid_q;
      wb_reg_write_q   <= mem_reg_write_q;
      wb_rd_q          <= mem_rd_q;
      flags_q          <= flags_d;
    end
  end

  assign bus.ex_alu_op      = ex_alu_op_q;
  assign bus.ex_alu_src     = ex_alu_src_q;
  assign bus.ex_flag_write  = ex_valid_q & ex_flag_write_q;
  assign bus.mem_mem_write  = mem_valid_q & mem_mem_write_q;
  assign bus.mem_mem_to_reg = mem_valid_q & mem_mem_to_reg_q;
  assign bus.wb_reg_write   = wb_valid_q & wb_reg_write_q;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.flags_q        = flags_q;

  assign unused_bits = ^{bus.id_instr[15:10], bus.ex_nzcv[2:1]};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench: two control units (flag forwarding + delay slot, and neither) share one stimulus.
module tb_pipe_ctrl_unit;
  localparam logic [10:0] OP_ADDS = 11'h558;
  localparam logic [10:0] OP_SUBS = 11'h758;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [31:0] id_instr = '0;
  logic id_valid = 1'b0;
  logic id_rt_zero = 1'b0;
  logic [3:0] ex_nzcv = '0;
  int checks = 0;
  int errors = 0;

  pipe_ctrl_if #(.ALUOP_W(3), .REG_AW(5)) if_f ();
  pipe_ctrl_if #(.ALUOP_W(3), .REG_AW(5)) if_s ();

  assign if_f.id_instr = id_instr;   assign if_s.id_instr = id_instr;
  assign if_f.id_valid = id_valid;   assign if_s.id_valid = id_valid;
  assign if_f.id_rt_zero = id_rt_zero; assign if_s.id_rt_zero = id_rt_zero;
  assign if_f.ex_nzcv = ex_nzcv;     assign if_s.ex_nzcv = ex_nzcv;

  pipe_ctrl_unit #(.ALUOP_W(3), .REG_AW(5), .EN_FLAG_FWD(1), .DELAY_SLOT(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .bus(if_f));
  pipe_ctrl_unit #(.ALUOP_W(3), .REG_AW(5), .EN_FLAG_FWD(0), .DELAY_SLOT(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(if_s));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [4:0] rn,
                                        input logic [4:0] rt);
    return {op, 9'd0, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rn, input logic [4:0] rd);
    return {10'b1001000100, 12'd1, rn, rd};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [4:0] rt);
    return {8'hB4, 19'd4, rt};
  endfunction
  function automatic logic [31:0] enc_blt();
    return {8'h54, 19'd4, 5'h0B};
  endfunction
  function automatic logic [31:0] enc_b();
    return {6'b000101, 26'd8};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    id_instr = ins;
    id_valid = v;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(32'd0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++; if (if_f.wb_reg_write !== 1'b0) begin errors++; $display("FAIL rst_wb: got %b exp 0", if_f.wb_reg_write); end
    checks++; if (if_f.flags_q !== 4'h0) begin errors++; $display("FAIL rst_flags: got %h exp 0", if_f.flags_q); end
    checks++; if (if_s.pc_write_en !== 1'b1) begin errors++; $display("FAIL rst_pcwe: got %b exp 1", if_s.pc_write_en); end
    checks++; if (if_f.ex_alu_op !== 3'b000) begin errors++; $display("FAIL rst_aluop: got %b exp 000", if_f.ex_alu_op); end
    tick(); tick();
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_load_use();
    drive(enc_d(OP_LDUR, 5'd2, 5'd1), 1'b1);
    checks++; if (if_f.pc_write_en !== 1'b1) begin errors++; $display("FAIL lu_c0_pcwe: got %b exp 1", if_f.pc_write_en); end
    tick();
    drive(enc_r(OP_ADDS, 5'd4, 5'd1, 5'd3), 1'b1);
    checks++; if (if_f.pc_write_en !== 1'b0) begin errors++; $display("FAIL lu_stall_f: got %b exp 0", if_f.pc_write_en); end
    checks++; if (if_s.pc_write_en !== 1'b0) begin errors++; $display("FAIL lu_stall_s: got %b exp 0", if_s.pc_write_en); end
    tick();
    checks++; if (if_f.pc_write_en !== 1'b1) begin errors++; $display("FAIL lu_release: got %b exp 1", if_f.pc_write_en); end
    checks++; if (if_f.ex_flag_write !== 1'b0 || if_f.ex_alu_op !== 3'b000) begin errors++; $display("FAIL lu_bubble: got fw=%b op=%b exp 0/000", if_f.ex_flag_write, if_f.ex_alu_op); end
    checks++; if (if_f.mem_mem_to_reg !== 1'b1) begin errors++; $display("FAIL lu_mem2reg: got %b exp 1", if_f.mem_mem_to_reg); end
    tick();
    drive(32'd0, 1'b0);
    checks++; if (if_f.ex_flag_write !== 1'b1 || if_f.ex_alu_op !== 3'b010) begin errors++; $display("FAIL lu_adds_ex: got fw=%b op=%b exp 1/010", if_f.ex_flag_write, if_f.ex_alu_op); end
    checks++; if (if_f.wb_reg_write !== 1'b1 || if_f.wb_rd !== 5'd1) begin errors++; $display("FAIL lu_ldur_wb: got we=%b rd=%0d exp 1/1", if_f.wb_reg_write, if_f.wb_rd); end
    tick();
    checks++; if (if_f.wb_reg_write !== 1'b0) begin errors++; $display("FAIL lu_bubble_wb: got %b exp 0", if_f.wb_reg_write); end
    tick();
    checks++; if (if_f.wb_reg_write !== 1'b1 || if_f.wb_rd !== 5'd3) begin errors++; $display("FAIL lu_adds_wb: got we=%b rd=%0d exp 1/3", if_f.wb_reg_write, if_f.wb_rd); end
    tick();
  endtask

  task automatic test_hazard_cases();
    drive(enc_d(OP_LDUR, 5'd2, 5'd31), 1'b1);
    tick();
    drive(enc_r(OP_ADDS, 5'd31, 5'd31, 5'd3), 1'b1);
    checks++; if (if_f.pc_write_en !== 1'b1) begin errors++; $display("FAIL xzr_nostall: got %b exp 1", if_f.pc_write_en); end
    tick();
    drive(enc_d(OP_LDUR, 5'd2, 5'd9), 1'b1);
    tick();
    drive(enc_d(OP_STUR, 5'd2, 5'd9), 1'b1);
    checks++; if (if_f.pc_write_en !== 1'b0) begin errors++; $display("FAIL stur_rt_stall: got %b exp 0", if_f.pc_write_en); end
    checks++; if (if_f.id_reg2loc !== 1'b0) begin errors++; $display("FAIL stur_reg2loc: got %b exp 0", if_f.id_reg2loc); end
    tick();
    checks++; if (if_f.pc_write_en !== 1'b1) begin errors++; $display("FAIL stur_release: got %b exp 1", if_f.pc_write_en); end
    tick();
    drive(enc_d(OP_LDUR, 5'd2, 5'd4), 1'b1);
    tick();
    drive(enc_cbz(5'd4), 1'b1);
    id_rt_zero = 1'b1;
    #1;
    checks++; if (if_f.mem_mem_write !== 1'b1) begin errors++; $display("FAIL stur_mem_write: got %b exp 1", if_f.mem_mem_write); end
    checks++; if (if_f.pc_write_en !== 1'b0 || if_f.id_br_taken !== 1'b0) begin errors++; $display("FAIL cbz_stall: got pcwe=%b tk=%b exp 0/0", if_f.pc_write_en, if_f.id_br_taken); end
    checks++; if (if_s.flush_if !== 1'b0) begin errors++; $display("FAIL cbz_stall_flush: got %b exp 0", if_s.flush_if); end
    tick();
    checks++; if (if_f.id_br_taken !== 1'b1 || if_f.id_uncond_br !== 1'b0) begin errors++; $display("FAIL cbz_taken: got tk=%b un=%b exp 1/0", if_f.id_br_taken, if_f.id_uncond_br); end
    checks++; if (if_f.flush_if !== 1'b0) begin errors++; $display("FAIL cbz_ds1_flush: got %b exp 0", if_f.flush_if); end
    checks++; if (if_s.flush_if !== 1'b1) begin errors++; $display("FAIL cbz_ds0_flush: got %b exp 1", if_s.flush_if); end
    id_rt_zero = 1'b0;
    #1;
    checks++; if (if_f.id_br_taken !== 1'b0) begin errors++; $display("FAIL cbz_nonzero: got %b exp 0", if_f.id_br_taken); end
    tick();
    idle(3);
  endtask

  task automatic test_flags();
    drive(enc_blt(), 1'b1);
    checks++; if (if_f.id_br_taken !== 1'b0 || if_s.id_br_taken !== 1'b0) begin errors++; $display("FAIL blt_clear: got %b/%b exp 0/0", if_f.id_br_taken, if_s.id_br_taken); end
    tick();
    drive(enc_r(OP_SUBS, 5'd2, 5'd1, 5'd0), 1'b1);
    tick();
    drive(enc_blt(), 1'b1);
    ex_nzcv = 4'b1000;
    #1;
    checks++; if (if_f.id_br_taken !== 1'b1 || if_f.pc_write_en !== 1'b1) begin errors++; $display("FAIL blt_fwd: got tk=%b pcwe=%b exp 1/1", if_f.id_br_taken, if_f.pc_write_en); end
    checks++; if (if_s.pc_write_en !== 1'b0 || if_s.id_br_taken !== 1'b0) begin errors++; $display("FAIL blt_nofwd_stall: got pcwe=%b tk=%b exp 0/0", if_s.pc_write_en, if_s.id_br_taken); end
    tick();
    ex_nzcv = 4'b0000;
    #1;
    checks++; if (if_s.id_br_taken !== 1'b1 || if_s.pc_write_en !== 1'b1 || if_s.flush_if !== 1'b1) begin errors++; $display("FAIL blt_nofwd_taken: got tk=%b pcwe=%b fl=%b exp 1/1/1", if_s.id_br_taken, if_s.pc_write_en, if_s.flush_if); end
    checks++; if (if_f.flags_q !== 4'b1000 || if_s.flags_q !== 4'b1000) begin errors++; $display("FAIL flags_commit: got %h/%h exp 8/8", if_f.flags_q, if_s.flags_q); end
    tick();
    drive(enc_r(OP_SUBS, 5'd2, 5'd2, 5'd0), 1'b1);
    tick();
    drive(enc_blt(), 1'b1);
    ex_nzcv = 4'b0100;
    #1;
    checks++; if (if_f.id_br_taken !== 1'b0) begin errors++; $display("FAIL blt_fwd_not_lt: got %b exp 0", if_f.id_br_taken); end
    checks++; if (if_s.pc_write_en !== 1'b0) begin errors++; $display("FAIL blt_stall2: got %b exp 0", if_s.pc_write_en); end
    tick();
    ex_nzcv = 4'b0000;
    drive(enc_b(), 1'b1);
    checks++; if (if_f.flags_q !== 4'b0100 || if_s.flags_q !== 4'b0100) begin errors++; $display("FAIL flags_stall_commit: got %h/%h exp 4/4", if_f.flags_q, if_s.flags_q); end
    checks++; if (if_f.id_br_taken !== 1'b1 || if_f.id_uncond_br !== 1'b1 || if_f.flush_if !== 1'b0) begin errors++; $display("FAIL b_f: got tk=%b un=%b fl=%b exp 1/1/0", if_f.id_br_taken, if_f.id_uncond_br, if_f.flush_if); end
    checks++; if (if_s.flush_if !== 1'b1) begin errors++; $display("FAIL b_s_flush: got %b exp 1", if_s.flush_if); end
    tick();
    idle(3);
  endtask

  task automatic test_illegal();
    logic [31:0] bad;
    bad = {11'h7FF, 21'd0};
    drive(enc_addi(5'd2, 5'd2), 1'b1);
    checks++; if (if_f.illegal !== 1'b0) begin errors++; $display("FAIL addi_legal: got %b exp 0", if_f.illegal); end
    tick();
    drive(bad, 1'b1);
    checks++; if (if_f.illegal !== 1'b1 || if_s.illegal !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b/%b exp 1/1", if_f.illegal, if_s.illegal); end
    checks++; if (if_f.ex_alu_src !== 2'b10) begin errors++; $display("FAIL addi_src: got %b exp 10", if_f.ex_alu_src); end
    tick();
    drive(bad, 1'b0);
    checks++; if (if_f.illegal !== 1'b0) begin errors++; $display("FAIL illegal_invalid: got %b exp 0", if_f.illegal); end
    checks++; if (if_f.ex_flag_write !== 1'b0 || if_f.ex_alu_op !== 3'b000) begin errors++; $display("FAIL illegal_ex_bubble: got fw=%b op=%b exp 0/000", if_f.ex_flag_write, if_f.ex_alu_op); end
    tick();
    checks++; if (if_f.wb_reg_write !== 1'b1 || if_f.wb_rd !== 5'd2) begin errors++; $display("FAIL addi_wb: got we=%b rd=%0d exp 1/2", if_f.wb_reg_write, if_f.wb_rd); end
    checks++; if (if_f.mem_mem_write !== 1'b0) begin errors++; $display("FAIL illegal_mem: got %b exp 0", if_f.mem_mem_write); end
    tick();
    checks++; if (if_f.wb_reg_write !== 1'b0 || if_f.flags_q !== 4'b0100) begin errors++; $display("FAIL illegal_wb: got we=%b flags=%h exp 0/4", if_f.wb_reg_write, if_f.flags_q); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    drive(enc_r(OP_SUBS, 5'd2, 5'd1, 5'd0), 1'b1);
    tick();
    drive(enc_addi(5'd7, 5'd7), 1'b1);
    ex_nzcv = 4'b1000;
    tick();
    ex_nzcv = 4'b0000;
    drive(enc_d(OP_LDUR, 5'd2, 5'd1), 1'b1);
    tick();
    drive(enc_r(OP_ADDS, 5'd4, 5'd1, 5'd3), 1'b1);
    checks++; if (if_f.pc_write_en !== 1'b0 || if_f.wb_reg_write !== 1'b1 || if_f.flags_q !== 4'b1000) begin errors++; $display("FAIL pre_rst: got pcwe=%b we=%b flags=%h exp 0/1/8", if_f.pc_write_en, if_f.wb_reg_write, if_f.flags_q); end
    checks++; if (if_f.ex_alu_op !== 3'b010) begin errors++; $display("FAIL pre_rst_aluop: got %b exp 010", if_f.ex_alu_op); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (if_f.wb_reg_write !== 1'b0 || if_f.flags_q !== 4'h0) begin errors++; $display("FAIL mid_rst_state: got we=%b flags=%h exp 0/0", if_f.wb_reg_write, if_f.flags_q); end
    checks++; if (if_f.pc_write_en !== 1'b1 || if_s.pc_write_en !== 1'b1) begin errors++; $display("FAIL mid_rst_pcwe: got %b/%b exp 1/1", if_f.pc_write_en, if_s.pc_write_en); end
    checks++; if (if_f.ex_alu_op !== 3'b000 || if_f.id_br_taken !== 1'b0) begin errors++; $display("FAIL mid_rst_ex: got op=%b tk=%b exp 000/0", if_f.ex_alu_op, if_f.id_br_taken); end
    tick();
    reset_n = 1'b1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_hazard_cases();
    test_flags();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
